// File: rtl/tc_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, address width
// and the bytes-per-word helper.
package tc_loader_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// Little-endian byte packer: places each accepted byte at the current byte lane
// and reports when the lane being written is the last one of the word.
module tc_byte_packer
  import tc_loader_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [7:0]           data,
  output logic [BIT_WIDTH-1:0] word,
  output logic                 word_full
);

  localparam int BYTES = bytes_per_word(BIT_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [BIT_WIDTH-1:0] pack_q, pack_d;

  assign word      = pack_q;
  assign word_full = (byte_idx_q == IDX_W'(BYTES - 1));

  // clear wins over accept; lanes not yet written stay zero
  always_comb begin
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    if (clear) begin
      byte_idx_d = '0;
      pack_d     = '0;
    end else if (accept) begin
      pack_d[8*byte_idx_q +: 8] = data;
      if (word_full) begin
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end else begin
      byte_idx_d = byte_idx_q;
      pack_d     = pack_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      pack_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
    end
  end

endmodule

// File: rtl/tc_program_loader.sv
// Byte-stream program loader: packs incoming bytes into program words, writes them
// to consecutive addresses and holds the CPU in reset while a load is running.
module tc_program_loader
  import tc_loader_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int BIT_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          word_count,
  output logic                 cpu_rst
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              last_q, last_d;
  logic              clear_s, accept_s;
  logic              word_full_s;
  logic [BIT_WIDTH-1:0] word_s;
  logic              depth_hit_s;

  tc_byte_packer #(.BIT_WIDTH(BIT_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .accept    (accept_s),
    .data      (in_data),
    .word      (word_s),
    .word_full (word_full_s)
  );

  // widened so a full 16-bit counter cannot wrap in the depth comparison
  assign depth_hit_s = (({1'b0, count_q} + 17'd1) == 17'(BIT_DEPTH));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    clear_s  = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RECV;
          addr_d  = start_addr;
          count_d = 16'd0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
          clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      RECV: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (word_full_s || in_last) begin
            state_d = WRITE;
            last_d  = in_last;
          end else begin
            state_d = RECV;
          end
        end else begin
          state_d = RECV;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 16'd1;
        count_d = count_q + 16'd1;
        clear_s = 1'b1;
        if (last_q) begin
          state_d = DONE;
        end else if (depth_hit_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RECV;
        end
      end
      DRAIN: begin
        if (in_valid) begin
          ovf_d = 1'b1;
          if (in_last) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= 16'd0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == RECV) || (state_q == DRAIN);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_s;
  assign busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign overflow   = ovf_q;
  assign word_count = count_q;
  assign cpu_rst    = busy | rst;

endmodule

// File: tb/tb_tc_program_loader.sv
// Directed bench for tc_program_loader: a word-level model predicts every memory
// write and end-of-load status; a negedge monitor checks each write against it.
module tb_tc_program_loader;

  localparam int BW = 16;
  localparam int BD = 4;
  localparam int NB = BW / 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last;
  logic [15:0]   start_addr;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, busy, done, overflow, cpu_rst;
  logic [15:0]   mem_addr, word_count;
  logic [BW-1:0] mem_wdata;

  typedef struct packed {
    logic [15:0]   a;
    logic [BW-1:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        cap_q[$];
  wr_t        mon_e;
  wr_t        tmp_e;
  logic [7:0] stim [0:15];
  int         errors = 0;
  int         checks = 0;

  tc_program_loader #(.BIT_WIDTH(BW), .BIT_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .overflow(overflow), .word_count(word_count), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // every write strobe must match the next word the model predicted
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        chk("wr_data", 32'(mem_wdata), 32'(mon_e.d));
      end
      chk("ready_in_write", 32'(in_ready), 32'd0);
      chk("cpu_rst_in_write", 32'(cpu_rst), 32'd1);
      tmp_e.a = mem_addr;
      tmp_e.d = mem_wdata;
      cap_q.push_back(tmp_e);
    end
  end

  task automatic send(input logic [7:0] b, input bit last, input bit exp_wr, input bit exp_imm);
    int w = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no in_ready in %0d cycles expected ready", w);
    end
    if (exp_imm) chk("drain_ready", 32'(w), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("we_latency", 32'(mem_we), 32'(exp_wr));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input int n, input bit gap);
    int nw;
    bit ovf;
    bit wr;
    nw  = (n + NB - 1) / NB;
    ovf = (nw > BD);
    if (ovf) nw = BD;
    cap_q.delete();
    for (int k = 0; k < nw; k++) begin
      wr_t e;
      e.a = a + 16'(k);
      e.d = '0;
      for (int j = 0; j < NB; j++)
        if (k * NB + j < n) e.d[8*j +: 8] = stim[k*NB + j];
      exp_q.push_back(e);
    end
    start = 1'b1;
    start_addr = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_count", 32'(word_count), 32'd0);
    chk("start_ovf", 32'(overflow), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
    wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit lst;
      bit drp;
      lst = (i == n - 1);
      drp = (i / NB) >= BD;
      wr  = !drp && ((i % NB == NB - 1) || lst);
      if (gap && i > 0) @(negedge clk);
      send(stim[i], lst, wr, i > BD * NB);
      if (!lst) chk("cpu_rst_mid", 32'(cpu_rst), 32'd1);
    end
    if (wr) @(negedge clk);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("end_ready", 32'(in_ready), 32'd0);
    chk("end_count", 32'(word_count), 32'(nw));
    chk("end_ovf", 32'(overflow), 32'(ovf));
    chk("end_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = 16'h0000;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd0);

    // two full words
    stim[0] = 8'h34; stim[1] = 8'h12; stim[2] = 8'h78; stim[3] = 8'h56;
    load(16'h0010, 4, 1'b0);
    chk("t1_nwr", 32'(cap_q.size()), 32'd2);
    if (cap_q.size() == 2) begin
      chk("t1_a0", 32'(cap_q[0].a), 32'h0010);
      chk("t1_d0", 32'(cap_q[0].d), 32'h1234);
      chk("t1_a1", 32'(cap_q[1].a), 32'h0011);
      chk("t1_d1", 32'(cap_q[1].d), 32'h5678);
    end

    // partial final word keeps its upper byte at zero
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    load(16'h0020, 3, 1'b0);
    chk("t2_nwr", 32'(cap_q.size()), 32'd2);
    if (cap_q.size() == 2) begin
      chk("t2_d0", 32'(cap_q[0].d), 32'hBBAA);
      chk("t2_d1", 32'(cap_q[1].d), 32'h00CC);
    end

    // overflow: 10 bytes into a 4-word image
    for (int i = 0; i < 10; i++) stim[i] = 8'(i + 1);
    load(16'h0000, 10, 1'b0);
    chk("t3_nwr", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      chk("t3_a3", 32'(cap_q[3].a), 32'h0003);
      chk("t3_d3", 32'(cap_q[3].d), 32'h0807);
    end
    chk("t3_ovf", 32'(overflow), 32'd1);

    // exact fit at the depth limit, then address wrap
    load(16'h0030, 8, 1'b0);
    chk("t4_ovf", 32'(overflow), 32'd0);
    load(16'hFFFF, 4, 1'b0);
    if (cap_q.size() == 2) begin
      chk("t4_wrap_a0", 32'(cap_q[0].a), 32'hFFFF);
      chk("t4_wrap_a1", 32'(cap_q[1].a), 32'h0000);
    end else begin
      chk("t4_wrap_nwr", 32'(cap_q.size()), 32'd2);
    end

    // valid toggling every other cycle
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
    load(16'h0100, 4, 1'b1);

    // start mid-load ignored, then reset aborts a partial word
    cap_q.delete();
    tmp_e.a = 16'h0040;
    tmp_e.d = 16'h2211;
    exp_q.push_back(tmp_e);
    start = 1'b1; start_addr = 16'h0040;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    send(8'h11, 1'b0, 1'b0, 1'b0);
    start = 1'b1; start_addr = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    chk("t6_busy_after_start", 32'(busy), 32'd1);
    chk("t6_ready_after_start", 32'(in_ready), 32'd1);
    send(8'h22, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    send(8'h33, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_addr", 32'(mem_addr), 32'd0);
    chk("t6_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("t6_rst_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_nwr", 32'(cap_q.size()), 32'd1);
    stim[0] = 8'h5A; stim[1] = 8'hA5;
    load(16'h0200, 2, 1'b0);
    if (cap_q.size() == 1) chk("t6_reload_d", 32'(cap_q[0].d), 32'hA55A);
    else chk("t6_reload_nwr", 32'(cap_q.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
